mod_updown_counter: RTL and testbench

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/counter_pkg.sv | 7 +
 rtl/mod_updown_counter_step.sv | 56 +++++
 rtl/mod_updown_counter.sv | 75 +++++++
 tb/tb_mod_updown_counter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Constants shared by the modulo up/down counter, its step logic and its benches.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/mod_updown_counter_step.sv
// Combinational next-count, wrap and boundary logic for the modulo counter.
// Saturation is controlled by i_sat; the top ties it low when COUNTER_SAT_EN is undefined.
module mod_step
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_next_count,
  output logic             o_wrap,
  output logic [WIDTH-1:0] o_load_count,
  output logic             o_at_bound
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable and never clamps.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  logic w_at_max;
  logic w_at_zero;

  assign w_at_max  = (i_count == MAX_COUNT);
  assign w_at_zero = (i_count == '0);

  always_comb begin
    o_next_count = i_count;
    o_wrap       = 1'b0;
    if (i_dir == DIR_UP) begin
      if (w_at_max) begin
        if (!i_sat) begin
          o_next_count = '0;
          o_wrap       = 1'b1;
        end
      end else begin
        o_next_count = i_count + WIDTH'(1);
      end
    end else begin
      if (w_at_zero) begin
        if (!i_sat) begin
          o_next_count = MAX_COUNT;
          o_wrap       = 1'b1;
        end
      end else begin
        o_next_count = i_count - WIDTH'(1);
      end
    end
  end

  assign o_load_count = ({1'b0, i_load_val} >= MOD_EXT) ? MAX_COUNT : i_load_val;
  assign o_at_bound   = (i_dir == DIR_UP) ? w_at_max : w_at_zero;

endmodule : mod_step

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with load, wrap pulse and boundary flag.
// Define COUNTER_SAT_EN to add the sat port (hold at the boundary instead of wrapping).
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_bound
);

  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_params
      $error("mod_updown_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_step_count;
  logic             w_step_wrap;
  logic [WIDTH-1:0] w_load_count;
  logic             w_sat;

`ifdef COUNTER_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  mod_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .i_count      (r_count),
    .i_dir        (dir),
    .i_sat        (w_sat),
    .i_load_val   (load_val),
    .o_next_count (w_step_count),
    .o_wrap       (w_step_wrap),
    .o_load_count (w_load_count),
    .o_at_bound   (at_bound)
  );

  // Priority: reset, load, enabled step, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_count;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_count <= w_step_count;
      r_wrap  <= w_step_wrap;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an arithmetic model.
module tb_mod_updown_counter;
  import counter_pkg::*;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef COUNTER_SAT_EN
  logic             sat;
`endif
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             at_bound;

  int total = 0;
  int bad   = 0;

  int m_count = 0;
  bit m_wrap  = 1'b0;

  mod_updown_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
`ifdef COUNTER_SAT_EN
    .sat      (sat),
`endif
    .count    (count),
    .wrap     (wrap),
    .at_bound (at_bound)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model by the stated rules, sample 1 ns after the edge.
  task automatic tick(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                      input logic e, input logic d, input logic s);
    bit hold_at_bound;
    rst = r; load = ld; load_val = lv; en = e; dir = d;
`ifdef COUNTER_SAT_EN
    sat = s;
    hold_at_bound = s;
`else
    hold_at_bound = 1'b0;
`endif
    @(posedge clk);
    if (r) begin
      m_count = 0; m_wrap = 1'b0;
    end else if (ld) begin
      m_count = (int'(lv) >= MODULUS) ? MODULUS - 1 : int'(lv);
      m_wrap  = 1'b0;
    end else if (e) begin
      int raw;
      raw = d ? m_count + 1 : m_count - 1;
      if (raw < 0 || raw >= MODULUS) begin
        m_wrap  = !hold_at_bound;
        m_count = hold_at_bound ? m_count : (raw + MODULUS) % MODULUS;
      end else begin
        m_count = raw; m_wrap = 1'b0;
      end
    end else begin
      m_wrap = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 4'd7, 1'b1, DIR_DOWN, 1'b0);
    total++;
    if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++;
    if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b want=0", wrap); end
    total++;
    if (at_bound !== 1'b1) begin bad++; $display("FAIL reset_at_bound_down got=%0b want=1", at_bound); end
    $display("reset: count=%0d wrap=%0b at_bound=%0b", count, wrap, at_bound);
  endtask

  task automatic test_up_wrap();
    int exp_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    tick(1'b1, 1'b0, 4'd0, 1'b0, DIR_UP, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 4'd0, 1'b1, DIR_UP, 1'b0);
      total++;
      if (count !== 4'(exp_cnt[i])) begin bad++; $display("FAIL up_count[%0d] got=%0d want=%0d", i, count, exp_cnt[i]); end
      total++;
      if (wrap !== (i == 9)) begin bad++; $display("FAIL up_wrap[%0d] got=%0b want=%0b", i, wrap, i == 9); end
      $display("up: cyc=%0d count=%0d wrap=%0b", i, count, wrap);
    end
  endtask

  task automatic test_down_wrap();
    int exp_cnt [5] = '{2, 1, 0, 9, 8};
    tick(1'b0, 1'b1, 4'd3, 1'b0, DIR_DOWN, 1'b0);
    total++;
    if (count !== 4'd3) begin bad++; $display("FAIL down_load got=%0d want=3", count); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 4'd0, 1'b1, DIR_DOWN, 1'b0);
      total++;
      if (count !== 4'(exp_cnt[i])) begin bad++; $display("FAIL down_count[%0d] got=%0d want=%0d", i, count, exp_cnt[i]); end
      total++;
      if (wrap !== (i == 3)) begin bad++; $display("FAIL down_wrap[%0d] got=%0b want=%0b", i, wrap, i == 3); end
      $display("down: cyc=%0d count=%0d wrap=%0b", i, count, wrap);
    end
  endtask

  task automatic test_load_clamp();
    tick(1'b0, 1'b1, 4'd14, 1'b0, DIR_UP, 1'b0);
    total++;
    if (count !== 4'd9) begin bad++; $display("FAIL load_clamp got=%0d want=9", count); end
    total++;
    if (at_bound !== 1'b1) begin bad++; $display("FAIL load_clamp_at_bound got=%0b want=1", at_bound); end
    $display("load14: count=%0d", count);
    tick(1'b0, 1'b1, 4'd5, 1'b1, DIR_UP, 1'b0);
    total++;
    if (count !== 4'd5) begin bad++; $display("FAIL load_over_en got=%0d want=5", count); end
    total++;
    if (wrap !== 1'b0) begin bad++; $display("FAIL load_over_en_wrap got=%0b want=0", wrap); end
    $display("load5+en: count=%0d wrap=%0b", count, wrap);
  endtask

  task automatic test_reset_midcount();
    tick(1'b0, 1'b1, 4'd6, 1'b0, DIR_UP, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 1'b1, DIR_UP, 1'b0);
    total++;
    if (count !== 4'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", count); end
    total++;
    if (wrap !== 1'b0) begin bad++; $display("FAIL midreset_wrap got=%0b want=0", wrap); end
    tick(1'b0, 1'b0, 4'd0, 1'b1, DIR_UP, 1'b0);
    total++;
    if (count !== 4'd1) begin bad++; $display("FAIL midreset_resume got=%0d want=1", count); end
    $display("midreset: resumed count=%0d", count);
  endtask

  task automatic test_alternate_en();
    int exp_cnt [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
    tick(1'b1, 1'b0, 4'd0, 1'b0, DIR_UP, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 4'd0, (i % 2) == 0, DIR_UP, 1'b0);
      total++;
      if (count !== 4'(exp_cnt[i])) begin bad++; $display("FAIL alt_count[%0d] got=%0d want=%0d", i, count, exp_cnt[i]); end
      total++;
      if (at_bound !== 1'b0) begin bad++; $display("FAIL alt_at_bound[%0d] got=%0b want=0", i, at_bound); end
      $display("alt: cyc=%0d count=%0d at_bound=%0b", i, count, at_bound);
    end
  endtask

`ifdef COUNTER_SAT_EN
  task automatic test_saturate();
    tick(1'b0, 1'b1, 4'd8, 1'b0, DIR_UP, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 4'd0, 1'b1, DIR_UP, 1'b1);
      total++;
      if (count !== 4'd9) begin bad++; $display("FAIL sat_count[%0d] got=%0d want=9", i, count); end
      total++;
      if (wrap !== 1'b0) begin bad++; $display("FAIL sat_wrap[%0d] got=%0b want=0", i, wrap); end
      total++;
      if (at_bound !== 1'b1) begin bad++; $display("FAIL sat_at_bound[%0d] got=%0b want=1", i, at_bound); end
      $display("sat: cyc=%0d count=%0d wrap=%0b at_bound=%0b", i, count, wrap, at_bound);
    end
    tick(1'b0, 1'b0, 4'd0, 1'b1, DIR_DOWN, 1'b1);
    total++;
    if (count !== 4'd8) begin bad++; $display("FAIL sat_reverse got=%0d want=8", count); end
    $display("sat: reversed count=%0d", count);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic r, ld, e, d, s;
      logic [WIDTH-1:0] lv;
      r  = ($urandom_range(0, 29) == 0);
      ld = ($urandom_range(0, 7) == 0);
      lv = WIDTH'($urandom_range(0, 15));
      e  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 4) != 0) ? (i / 40) % 2 == 0 : 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      tick(r, ld, lv, e, d, s);
      total++;
      if (count !== 4'(m_count)) begin bad++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, count, m_count); end
      total++;
      if (wrap !== m_wrap) begin bad++; $display("FAIL rnd_wrap[%0d] got=%0b want=%0b", i, wrap, m_wrap); end
      total++;
      if (at_bound !== (d ? (m_count == MODULUS - 1) : (m_count == 0))) begin
        bad++; $display("FAIL rnd_at_bound[%0d] got=%0b dir=%0b count=%0d", i, at_bound, d, m_count);
      end
      $display("rnd: cyc=%0d rst=%0b load=%0b lv=%0d en=%0b dir=%0b count=%0d wrap=%0b", i, r, ld, lv, e, d, count, wrap);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = DIR_UP; load = 1'b0; load_val = '0;
`ifdef COUNTER_SAT_EN
    sat = 1'b0;
`endif
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_reset_midcount();
    test_alternate_en();
`ifdef COUNTER_SAT_EN
    test_saturate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_updown_counter
